// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_SWEEP
  } rf_state_e;

  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_NUM_RD   = 2;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: mux, x0 handling, ready bit.
// With REGFILE_BYPASS_EN the writeback value is forwarded same cycle.
module regfile_read_port #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                       busy,
  input  logic [NUM_REGS*DATA_W-1:0] mem_flat,
  input  logic [NUM_REGS-1:0]        pend,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [AW-1:0]              raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rrdy
);

  logic hit;
  logic sel_busy;
  logic sel_zero;
  logic sel_fwd;

`ifdef REGFILE_BYPASS_EN
  assign hit = we && (raddr == waddr);
`else
  logic unused_byp;
  assign hit        = 1'b0;
  assign unused_byp = ^{we, waddr, wdata};
`endif

  assign sel_busy = busy;
  assign sel_zero = !busy && (raddr == '0);
  assign sel_fwd  = !busy && (raddr != '0) && hit;

  // select data/ready source for this port
  always_comb begin
    rdata = '0;
    rrdy  = 1'b0;
    unique case (1'b1)
      sel_busy: begin
        rdata = '0;
        rrdy  = 1'b0;
      end
      sel_zero: begin
        rdata = '0;
        rrdy  = 1'b1;
      end
      sel_fwd: begin
        rdata = wdata;
        rrdy  = 1'b1;
      end
      default: begin
        rdata = mem_flat[int'(raddr)*DATA_W +: DATA_W];
        rrdy  = !pend[raddr];
      end
    endcase
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending bits and a clear sweep.
// Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = RF_NUM_RD,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pend_set,
  input  logic [AW-1:0]            pend_addr,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rrdy
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  rf_state_e state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic [DATA_W-1:0]          mem [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] mem_flat;
  logic [NUM_REGS-1:0]        pend;

  assign busy = (state == RF_SWEEP);

  // sweep FSM state and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_SWEEP;
      cnt   <= ONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // sweep next state: restart on clear, leave after last entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RF_IDLE: begin
        if (clear_req) begin
          state_nxt = RF_SWEEP;
          cnt_nxt   = ONE;
        end
      end
      RF_SWEEP: begin
        if (clear_req) begin
          cnt_nxt = ONE;
        end else if (cnt == LAST) begin
          state_nxt = RF_IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = RF_IDLE;
        cnt_nxt   = ONE;
      end
    endcase
  end

  // storage: sweep zeroes one entry per cycle, else writeback
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (!reset && we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // scoreboard: write clears, issue sets; issue wins on collision
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (!busy) begin
      if (we && (waddr != '0)) begin
        pend[waddr] <= 1'b0;
      end
      if (pend_set && (pend_addr != '0)) begin
        pend[pend_addr] <= 1'b1;
      end
    end
  end

  // flatten array for the read ports; x0 is forced to zero
  always_comb begin
    mem_flat = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      mem_flat[i*DATA_W +: DATA_W] = mem[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .AW      (AW)
    ) u_port (
      .busy    (busy),
      .mem_flat(mem_flat),
      .pend    (pend),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (raddr[k*AW +: AW]),
      .rdata   (rdata[k*DATA_W +: DATA_W]),
      .rrdy    (rrdy[k])
    );
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Randomised bench with a behavioural model for scoreboard_register_file.
// Honours REGFILE_BYPASS_EN when compiled with it.
module tb_scoreboard_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [7:0]  wdata = '0;
  logic        pend_set = 1'b0;
  logic [4:0]  pend_addr = '0;
  logic [9:0]  raddr = '0;
  logic [15:0] rdata;
  logic [1:0]  rrdy;

  logic        reset2 = 1'b1;
  logic        clear2 = 1'b0;
  logic        busy2;
  logic        we2 = 1'b0;
  logic [2:0]  waddr2 = '0;
  logic [15:0] wdata2 = '0;
  logic        pset2 = 1'b0;
  logic [2:0]  paddr2 = '0;
  logic [8:0]  raddr2 = '0;
  logic [47:0] rdata2;
  logic [2:0]  rrdy2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scoreboard_register_file dut (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .pend_set (pend_set),
    .pend_addr(pend_addr),
    .raddr    (raddr),
    .rdata    (rdata),
    .rrdy     (rrdy)
  );

  scoreboard_register_file #(
    .DATA_W  (16),
    .NUM_REGS(8),
    .NUM_RD  (3)
  ) dut2 (
    .clk      (clk),
    .reset    (reset2),
    .clear_req(clear2),
    .busy     (busy2),
    .we       (we2),
    .waddr    (waddr2),
    .wdata    (wdata2),
    .pend_set (pset2),
    .pend_addr(paddr2),
    .raddr    (raddr2),
    .rdata    (rdata2),
    .rrdy     (rrdy2)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // behavioural model: a sweep wipes everything; busy for 31 cycles
  logic [7:0] m_mem [32];
  bit         m_pend [32];
  int         left = 0;
  bit         armed = 0;

  always @(posedge clk) begin
    if (reset) begin
      armed = 1;
      left  = 31;
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 8'h00;
        m_pend[i] = 0;
      end
    end else if (left > 0) begin
      if (clear_req) left = 31;
      else left = left - 1;
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_pend[waddr] = 0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1;
      if (clear_req) begin
        left = 31;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [15:0] er;
    logic [1:0]  ey;
    int          a;
    if (armed) begin
      er = '0;
      ey = '0;
      for (int k = 0; k < 2; k++) begin
        a = int'(raddr[k*5 +: 5]);
        if (left > 0) begin
          er[k*8 +: 8] = 8'h00;
          ey[k] = 1'b0;
        end else if (a == 0) begin
          er[k*8 +: 8] = 8'h00;
          ey[k] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        end else if (we && a == int'(waddr)) begin
          er[k*8 +: 8] = wdata;
          ey[k] = 1'b1;
`endif
        end else begin
          er[k*8 +: 8] = m_mem[a];
          ey[k] = !m_pend[a];
        end
      end
      check("busy", 64'(busy), 64'(left > 0));
      check("rdata", 64'(rdata), 64'(er));
      check("rrdy", 64'(rrdy), 64'(ey));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    tick();
  endtask

  task automatic idle_in();
    we = 0;
    pend_set = 0;
    clear_req = 0;
    reset = 0;
  endtask

  initial begin
    int n;
    tick();
    idle_in();
    count_busy(n);
    check("reset_sweep_len", 64'(n), 64'd31);

    raddr = {5'd31, 5'd12};
    @(negedge clk);
    check("post_reset_rd", 64'(rdata), 64'h0000);
    check("post_reset_rdy", 64'(rrdy), 64'h3);
    tick();

    we = 1; waddr = 5; wdata = 8'hA5; raddr = {5'd5, 5'd5};
    tick();
    we = 0;
    @(negedge clk);
    check("wr_x5", 64'(rdata), 64'hA5A5);
    tick();

    we = 1; waddr = 0; wdata = 8'hFF; raddr = '0;
    tick();
    we = 0;
    @(negedge clk);
    check("wr_x0", 64'({rdata, 6'd0, rrdy}), 64'h0000_03);
    tick();

    pend_set = 1; pend_addr = 7; raddr = {5'd0, 5'd7};
    tick();
    pend_set = 0;
    @(negedge clk);
    check("pend_x7", 64'(rrdy), 64'h2);
    tick();

    we = 1; waddr = 7; wdata = 8'h3C;
    tick();
    we = 0;
    @(negedge clk);
    check("wr_x7", 64'({rdata[7:0], 7'd0, rrdy[0]}), 64'h3C01);
    tick();

    we = 1; waddr = 9; wdata = 8'h5A;
    pend_set = 1; pend_addr = 9; raddr = {5'd9, 5'd9};
    tick();
    we = 0; pend_set = 0;
    @(negedge clk);
    check("pend_we_x9", 64'({rdata, 6'd0, rrdy}), 64'h5A5A_00);
    tick();

    we = 1; waddr = 3; wdata = 8'h22;
    tick();
    we = 0; pend_set = 1; pend_addr = 3;
    tick();
    pend_set = 0; we = 1; waddr = 3; wdata = 8'h11; raddr = {5'd0, 5'd3};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("bypass_x3", 64'({rdata[7:0], 7'd0, rrdy[0]}), 64'h1101);
`else
    check("nobypass_x3", 64'({rdata[7:0], 7'd0, rrdy[0]}), 64'h2200);
`endif
    tick();
    we = 0;
    tick();

    reset = 1;
    tick();
    reset = 0;
    we = 1; waddr = 4; wdata = 8'h77;
    repeat (9) tick();
    we = 0; clear_req = 1;
    tick();
    clear_req = 0;
    count_busy(n);
    check("clear_sweep_len", 64'(n), 64'd31);
    raddr = {5'd4, 5'd4};
    @(negedge clk);
    check("we_in_sweep", 64'({rdata, 6'd0, rrdy}), 64'h0000_03);
    tick();

    for (int c = 0; c < 1500; c++) begin
      we        = ($urandom_range(0, 2) != 0);
      waddr     = 5'($urandom);
      wdata     = 8'($urandom);
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom);
      raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      raddr[9:5] = ($urandom_range(0, 3) == 0) ? pend_addr : 5'($urandom);
      clear_req = ($urandom_range(0, 199) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle_in();
    tick();

    reset2 = 1;
    tick();
    reset2 = 0;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (!busy2) break;
      n++;
    end
    check("p2_sweep_len", 64'(n), 64'd7);
    tick();
    we2 = 1; waddr2 = 1; wdata2 = 16'hBEEF;
    tick();
    waddr2 = 2; wdata2 = 16'h1234;
    tick();
    we2 = 0; raddr2 = {3'd1, 3'd2, 3'd1};
    @(negedge clk);
    check("p2_rdata", 64'(rdata2), 64'hBEEF_1234_BEEF);
    check("p2_rrdy", 64'(rrdy2), 64'h7);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
